// File: rtl/branch_predictor_if.sv
// Lookup/update bundle between decode, execute and the branch direction predictor.
// The master drives lookups and resolved outcomes; the slave (the predictor) returns predictions.
interface branch_predictor_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned IW   = 6
);
    logic            lookup_valid;
    logic [XLEN-1:0] lookup_pc;
    logic            branch_prediction;
    logic [IW-1:0]   predict_index;
    logic            update_valid;
    logic [IW-1:0]   update_index;
    logic            update_taken;
    logic            update_mispredicted;
    logic [31:0]     mispredict_count;

    modport master (
        output lookup_valid, lookup_pc, update_valid, update_index, update_taken,
               update_mispredicted,
        input  branch_prediction, predict_index, mispredict_count
    );

    modport slave (
        input  lookup_valid, lookup_pc, update_valid, update_index, update_taken,
               update_mispredicted,
        output branch_prediction, predict_index, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Decode-stage direction predictor: table of 2-bit saturating counters with zero-latency lookup.
// Define BRANCH_PREDICTOR_GSHARE_EN to XOR a non-speculative global history into the index.
module branch_predictor #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned GHR_BITS    = 6
) (
    input logic               clk,
    input logic               rst_n,
    branch_predictor_if.slave bp
);
    localparam int unsigned IW = $clog2(BHT_ENTRIES);

    if (BHT_ENTRIES < 4 || (BHT_ENTRIES & (BHT_ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("BHT_ENTRIES must be a power of two, at least 4");
    end
    if (GHR_BITS > IW) begin : g_bad_ghr
        $error("GHR_BITS must not exceed log2(BHT_ENTRIES)");
    end

    logic [1:0]    cnt_q [BHT_ENTRIES];
    logic [1:0]    cnt_d [BHT_ENTRIES];
    logic [31:0]   miss_q, miss_d;
    logic [1:0]    upd_cnt;
    logic [IW-1:0] base_idx;
    logic [IW-1:0] lookup_idx;
    logic          unused_pc_bits;

    assign base_idx       = bp.lookup_pc[IW+1:2];
    assign unused_pc_bits = ^{bp.lookup_pc[XLEN-1:IW+2], bp.lookup_pc[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_q, ghr_d;

    // Only resolved branches enter the history; a coinciding lookup sees the pre-shift value.
    always_comb begin
        ghr_d = ghr_q;
        if (bp.update_valid) begin
            ghr_d = (ghr_q << 1) | GHR_BITS'(bp.update_taken);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign lookup_idx = base_idx ^ IW'(ghr_q);
`else
    assign lookup_idx = base_idx;
`endif

    assign bp.predict_index     = lookup_idx;
    assign bp.branch_prediction = bp.lookup_valid & cnt_q[lookup_idx][1];
    assign bp.mispredict_count  = miss_q;

    assign upd_cnt = cnt_q[bp.update_index];

    // Training uses the index carried down the pipe, never a recomputed one.
    always_comb begin
        cnt_d  = cnt_q;
        miss_d = miss_q;
        if (bp.update_valid) begin
            if (bp.update_taken) begin
                if (upd_cnt != 2'b11) begin
                    cnt_d[bp.update_index] = upd_cnt + 2'd1;
                end
            end else if (upd_cnt != 2'b00) begin
                cnt_d[bp.update_index] = upd_cnt - 2'd1;
            end
            if (bp.update_mispredicted && miss_q != 32'hFFFF_FFFF) begin
                miss_d = miss_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                cnt_q[i] <= 2'b01;
            end
            miss_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            miss_q <= miss_d;
        end
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Decode-stage direction predictor: the producer of the `branch_prediction` bit that the execute-stage branch evaluator checks.
- Holds a table of 2-bit saturating counters.
- Answers a same-cycle lookup for the instruction in decode.
- Trains on resolved outcomes (taken / mispredicted) returned from execute.
- The table index used at prediction time travels down the pipeline with the instruction and comes back on the update port.

Parameters:
- XLEN, 32, datapath / PC width.
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, minimum 4.
- GHR_BITS, 6, global history length; used only with GSHARE_EN; must be ≤ log2(BHT_ENTRIES).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- lookup_valid  input  1  decode holds a conditional branch.
- lookup_pc  input  XLEN  PC of that branch.
- branch_prediction  output  1  1 = predict taken.
- predict_index  output  log2(BHT_ENTRIES)  table index used for this prediction; pipelined with the instruction.
- update_valid  input  1  execute resolved a conditional branch this cycle.
- update_index  input  log2(BHT_ENTRIES)  predict_index carried with the resolving branch.
- update_taken  input  1  actual outcome (the evaluator's branch_taken).
- update_mispredicted  input  1  evaluator's branch_mispredicted for this branch.
- mispredict_count  output  32  saturating count of mispredictions since reset.

Behaviour:
- Index width: IW = log2(BHT_ENTRIES).
- Base index: lookup_pc[IW+1:2]. PC bits [1:0] are ignored.
- Lookup path is combinational from registered state (zero latency):
  - predict_index = base index (XOR history under GSHARE_EN).
  - branch_prediction = lookup_valid & counter[predict_index][1].
  - With lookup_valid = 0, branch_prediction = 0 and predict_index still reflects lookup_pc.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Update occurs on the rising clk edge when update_valid = 1:
  - update_taken = 1: counter[update_index] increments, saturating at 11.
  - update_taken = 0: counter[update_index] decrements, saturating at 00.
  - Exactly one entry is written per cycle.
- mispredict_count:
  - Increments by 1 on each edge with update_valid & update_mispredicted.
  - Saturates at 0xFFFF_FFFF and does not wrap.
  - update_mispredicted is ignored when update_valid = 0.
- Simultaneous lookup and update to the same index:
  - The lookup sees the pre-update counter value; there is no bypass.
  - The write takes effect on the next cycle's lookup.
- Reset (rst_n low, asynchronous, any time, including mid-update):
  - Every counter becomes 01.
  - mispredict_count becomes 0.
  - History register (if present) becomes 0.
  - Outputs during reset: branch_prediction = 0 for any lookup; predict_index follows lookup_pc.
  - An update presented while rst_n is low is discarded.
  - The first edge after rst_n deasserts may perform an update.
- No stall input. The surrounding pipeline must not present the same resolved branch on two cycles.
- update_index values are trusted; all IW bits select a valid entry.

Optional Feature:
- Macro: BRANCH_PREDICTOR_GSHARE_EN.
- Defined:
  - A GHR_BITS-wide global history register exists.
  - On each edge with update_valid = 1, it shifts left, inserting update_taken at bit 0. History is non-speculative: only resolved branches enter it.
  - predict_index = base index XOR zero-extended GHR.
  - Updates still use update_index unchanged, so a history shift between lookup and resolve never misdirects training.
  - If update_valid and lookup coincide, the lookup uses the pre-shift history.
- Undefined:
  - Pure bimodal predictor; predict_index = base index.
  - No history register is instantiated.
  - GHR_BITS is unused.

Test Plan (BHT_ENTRIES=64, bimodal unless noted):
1. Reset release, then lookup_valid = 1, lookup_pc = 0x0000_0100 -> predict_index = 0, branch_prediction = 0, mispredict_count = 0.
2. Two updates to index 0 with update_taken = 1, update_mispredicted = 1 on the first only -> next lookup of 0x100 predicts 1; counter is 11; mispredict_count = 1. A third taken update keeps the counter at 11 (saturation).
3. Same cycle: lookup of PC 0x104 (index 1) and update of index 1 with taken = 1 -> that cycle branch_prediction = 0; next cycle branch_prediction = 1.
4. Drive counter 3 to 00 with two not-taken updates, then a third not-taken update -> stays 00. Lookup of 0x10C predicts 0; lookup of 0x20C aliases to index 3 and also predicts 0.
5. Pull rst_n low asynchronously, mid-cycle, during an update_valid pulse -> all lookups immediately predict 0; mispredict_count = 0; after release, the written entry reads weak NT.
6. GSHARE_EN: three taken updates make GHR = 0b000111 -> lookup of 0x100 gives predict_index = 7. An update using the earlier carried update_index = 0 trains entry 0, not entry 7.
